powerup_effect_controller: RTL and testbench

- Downstream consumer of the collision detector's three sticky flags: obstacle collision, speed-powerup collision and shield-powerup collision.
- Converts each flag's rising edge into game effects:
  - a timed speed boost,
  - a timed shield that absorbs one obstacle hit and then grants a short invulnerability window,
  - a latched game-over.
- Feeds player movement (speed), the renderer (shield/invulnerability indicators) and the top-level game FSM (game_over).

---
 rtl/powerup_effect_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_powerup_effect_controller.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/powerup_effect_controller.sv
// Turns the collision detector's sticky flags into timed speed/shield effects and a latched game-over.
// Latency: an input flag rising is reflected on the registered outputs one clock later.
// Backpressure: none; flags are level inputs sampled every cycle, and outputs are always valid.
//
// Ports:
//   clock_100mhz, reset_n        : clock and asynchronous active-low reset
//   game_active                  : high while a game runs; low returns everything to idle
//   is_collision                 : sticky obstacle-collision flag
//   is_speed_powerup_collision   : sticky speed-pickup flag
//   is_shield_powerup_collision  : sticky shield-pickup flag
//   speed_active / shield_active : effect currently running
//   invuln_active                : grace window after the shield absorbed a hit
//   game_over                    : latched until game_active drops
//   speed_ms_left/shield_ms_left : raw remaining milliseconds of each effect
module powerup_effect_controller #(
  parameter int TICK_DIV  = 100000,
  parameter int SPEED_MS  = 5000,
  parameter int SHIELD_MS = 8000,
  parameter int GRACE_MS  = 1000,
  parameter int TIMER_W   = 16
) (
  input  logic               clock_100mhz,
  input  logic               reset_n,
  input  logic               game_active,
  input  logic               is_collision,
  input  logic               is_speed_powerup_collision,
  input  logic               is_shield_powerup_collision,
  output logic               speed_active,
  output logic               shield_active,
  output logic               invuln_active,
  output logic               game_over,
  output logic [TIMER_W-1:0] speed_ms_left,
  output logic [TIMER_W-1:0] shield_ms_left
);

  // A one-cycle-per-ms divider still needs a 1-bit counter to stay legal.
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CNT_W-1:0]   TICK_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [TIMER_W-1:0] SPEED_LD   = TIMER_W'(SPEED_MS);
  localparam logic [TIMER_W-1:0] SHIELD_LD  = TIMER_W'(SHIELD_MS);
  localparam logic [TIMER_W-1:0] GRACE_LD   = TIMER_W'(GRACE_MS);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] TIMER_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_OVER    = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;

  // Previous-cycle copies of the sticky flags, for rising-edge detection.
  logic               coll_flag_q, coll_flag_d;
  logic               speed_flag_q, speed_flag_d;
  logic               shield_flag_q, shield_flag_d;

  logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;

  logic [TIMER_W-1:0] speed_q, speed_d;
  logic [TIMER_W-1:0] shield_q, shield_d;
  logic [TIMER_W-1:0] grace_q, grace_d;

  logic               speed_active_q, speed_active_d;
  logic               shield_active_q, shield_active_d;
  logic               invuln_active_q, invuln_active_d;
  logic               game_over_q, game_over_d;

  // ---------------------------------------------------------------------------
  // Event and tick decode
  // ---------------------------------------------------------------------------
  logic coll_ev;
  logic speed_ev;
  logic shield_ev;
  logic tick;
  logic absorb;
  logic fatal_hit;

  assign coll_ev   = is_collision                & ~coll_flag_q;
  assign speed_ev  = is_speed_powerup_collision  & ~speed_flag_q;
  assign shield_ev = is_shield_powerup_collision & ~shield_flag_q;

  // The divider is held at zero outside RUNNING, so this only fires while running.
  assign tick = (state_q == ST_RUNNING) && (tick_cnt_q == TICK_LAST);

  // Collisions are judged against the registered effect state from the start
  // of the cycle, so a shield picked up in the same cycle does not protect.
  assign absorb    = coll_ev && !invuln_active_q &&  shield_active_q;
  assign fatal_hit = coll_ev && !invuln_active_q && !shield_active_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = '0;
    speed_d    = TIMER_ZERO;
    shield_d   = TIMER_ZERO;
    grace_d    = TIMER_ZERO;

    // Edge registers track the flags in every state; loading them while idle
    // means flags already high at game start never count as events.
    coll_flag_d   = is_collision;
    speed_flag_d  = is_speed_powerup_collision;
    shield_flag_d = is_shield_powerup_collision;

    unique case (state_q)
      ST_IDLE: begin
        if (game_active) begin
          state_d = ST_RUNNING;
        end
      end

      ST_RUNNING: begin
        tick_cnt_d = tick ? '0 : (tick_cnt_q + CNT_W'(1));

        // Speed: a pickup reloads to full (no stacking); load beats tick.
        if (speed_ev) begin
          speed_d = SPEED_LD;
        end else if (tick && (speed_q != TIMER_ZERO)) begin
          speed_d = speed_q - TIMER_ONE;
        end else begin
          speed_d = speed_q;
        end

        // Shield: a pickup wins over both the absorb clear and the tick.
        if (shield_ev) begin
          shield_d = SHIELD_LD;
        end else if (absorb) begin
          shield_d = TIMER_ZERO;
        end else if (tick && (shield_q != TIMER_ZERO)) begin
          shield_d = shield_q - TIMER_ONE;
        end else begin
          shield_d = shield_q;
        end

        // Grace: only an absorb loads it; a shield pickup leaves it running.
        if (absorb) begin
          grace_d = GRACE_LD;
        end else if (tick && (grace_q != TIMER_ZERO)) begin
          grace_d = grace_q - TIMER_ONE;
        end else begin
          grace_d = grace_q;
        end

        if (fatal_hit) begin
          state_d    = ST_OVER;
          tick_cnt_d = '0;
          speed_d    = TIMER_ZERO;
          shield_d   = TIMER_ZERO;
          grace_d    = TIMER_ZERO;
        end
      end

      ST_OVER: begin
        // Terminal until the game is torn down; timers stay forced to zero.
        state_d = ST_OVER;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Leaving the game overrides everything from any state.
    if (!game_active) begin
      state_d    = ST_IDLE;
      tick_cnt_d = '0;
      speed_d    = TIMER_ZERO;
      shield_d   = TIMER_ZERO;
      grace_d    = TIMER_ZERO;
    end

    speed_active_d  = (speed_d  != TIMER_ZERO);
    shield_active_d = (shield_d != TIMER_ZERO);
    invuln_active_d = (grace_d  != TIMER_ZERO);
    game_over_d     = (state_d  == ST_OVER);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      coll_flag_q     <= 1'b0;
      speed_flag_q    <= 1'b0;
      shield_flag_q   <= 1'b0;
      tick_cnt_q      <= '0;
      speed_q         <= TIMER_ZERO;
      shield_q        <= TIMER_ZERO;
      grace_q         <= TIMER_ZERO;
      speed_active_q  <= 1'b0;
      shield_active_q <= 1'b0;
      invuln_active_q <= 1'b0;
      game_over_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      coll_flag_q     <= coll_flag_d;
      speed_flag_q    <= speed_flag_d;
      shield_flag_q   <= shield_flag_d;
      tick_cnt_q      <= tick_cnt_d;
      speed_q         <= speed_d;
      shield_q        <= shield_d;
      grace_q         <= grace_d;
      speed_active_q  <= speed_active_d;
      shield_active_q <= shield_active_d;
      invuln_active_q <= invuln_active_d;
      game_over_q     <= game_over_d;
    end
  end

  assign speed_active   = speed_active_q;
  assign shield_active  = shield_active_q;
  assign invuln_active  = invuln_active_q;
  assign game_over      = game_over_q;
  assign speed_ms_left  = speed_q;
  assign shield_ms_left = shield_q;

endmodule

// File: tb/tb_powerup_effect_controller.sv
// Self-checking bench for powerup_effect_controller with a small tick divider.
// Latency: expectations are updated at each rising edge and compared on the falling edge.
// Backpressure: not applicable; every cycle applies one input vector.
module tb_powerup_effect_controller;

  localparam int TICK_DIV  = 4;
  localparam int SPEED_MS  = 5;
  localparam int SHIELD_MS = 6;
  localparam int GRACE_MS  = 3;
  localparam int TIMER_W   = 16;

  logic               clk;
  logic               reset_n;
  logic               game_active;
  logic               col;
  logic               spd;
  logic               shd;
  logic               speed_active;
  logic               shield_active;
  logic               invuln_active;
  logic               game_over;
  logic [TIMER_W-1:0] speed_ms_left;
  logic [TIMER_W-1:0] shield_ms_left;

  int vectors;
  int miscompares;

  powerup_effect_controller #(
    .TICK_DIV (TICK_DIV),
    .SPEED_MS (SPEED_MS),
    .SHIELD_MS(SHIELD_MS),
    .GRACE_MS (GRACE_MS),
    .TIMER_W  (TIMER_W)
  ) dut (
    .clock_100mhz               (clk),
    .reset_n                    (reset_n),
    .game_active                (game_active),
    .is_collision               (col),
    .is_speed_powerup_collision (spd),
    .is_shield_powerup_collision(shd),
    .speed_active               (speed_active),
    .shield_active              (shield_active),
    .invuln_active              (invuln_active),
    .game_over                  (game_over),
    .speed_ms_left              (speed_ms_left),
    .shield_ms_left             (shield_ms_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: game phase as two booleans, the ms divider as elapsed
  // running cycles modulo TICK_DIV, and effects as plain integer ms counts.
  // ---------------------------------------------------------------------------
  bit m_playing;
  bit m_over;
  int m_elapsed;
  int m_speed;
  int m_shield;
  int m_grace;
  bit p_col, p_spd, p_shd;

  task automatic model_reset();
    m_playing = 0; m_over = 0; m_elapsed = 0;
    m_speed = 0; m_shield = 0; m_grace = 0;
    p_col = 0; p_spd = 0; p_shd = 0;
  endtask

  task automatic model_step();
    bit hit, got_speed, got_shield, ms_tick, absorbed;
    if (!reset_n) begin
      model_reset();
      return;
    end
    hit        = col && !p_col;
    got_speed  = spd && !p_spd;
    got_shield = shd && !p_shd;
    if (!game_active) begin
      m_playing = 0; m_over = 0; m_elapsed = 0;
      m_speed = 0; m_shield = 0; m_grace = 0;
    end else if (!m_playing && !m_over) begin
      m_playing = 1;
      m_elapsed = 0;
    end else if (m_playing) begin
      ms_tick = (m_elapsed % TICK_DIV) == TICK_DIV - 1;
      m_elapsed++;
      if (hit && m_grace == 0 && m_shield == 0) begin
        m_playing = 0; m_over = 1;
        m_speed = 0; m_shield = 0; m_grace = 0;
      end else begin
        absorbed = hit && m_grace == 0 && m_shield > 0;
        if (got_speed) m_speed = SPEED_MS;
        else if (ms_tick && m_speed > 0) m_speed--;
        if (got_shield) m_shield = SHIELD_MS;
        else if (absorbed) m_shield = 0;
        else if (ms_tick && m_shield > 0) m_shield--;
        if (absorbed) m_grace = GRACE_MS;
        else if (ms_tick && m_grace > 0) m_grace--;
      end
    end
    p_col = col; p_spd = spd; p_shd = shd;
  endtask

  task automatic check_outputs(input string tag);
    vectors++;
    assert (speed_active === (m_speed > 0)) else begin
      miscompares++;
      $error("FAIL %s speed_active got %0b want %0b", tag, speed_active, (m_speed > 0));
    end
    vectors++;
    assert (shield_active === (m_shield > 0)) else begin
      miscompares++;
      $error("FAIL %s shield_active got %0b want %0b", tag, shield_active, (m_shield > 0));
    end
    vectors++;
    assert (invuln_active === (m_grace > 0)) else begin
      miscompares++;
      $error("FAIL %s invuln_active got %0b want %0b", tag, invuln_active, (m_grace > 0));
    end
    vectors++;
    assert (game_over === m_over) else begin
      miscompares++;
      $error("FAIL %s game_over got %0b want %0b", tag, game_over, m_over);
    end
    vectors++;
    assert (speed_ms_left === TIMER_W'(m_speed)) else begin
      miscompares++;
      $error("FAIL %s speed_ms_left got %0d want %0d", tag, speed_ms_left, m_speed);
    end
    vectors++;
    assert (shield_ms_left === TIMER_W'(m_shield)) else begin
      miscompares++;
      $error("FAIL %s shield_ms_left got %0d want %0d", tag, shield_ms_left, m_shield);
    end
  endtask

  // Directed spot check against a value fixed by the scenario itself.
  task automatic expect_val(input string tag, input int got, input int want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic bound_expired(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s timeout got not-reached want reached", tag);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    game_active = 1'b0;
    col = 1'b0; spd = 1'b0; shd = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs("reset");
    reset_n = 1'b1;

    // ---- Speed boost: load, per-ms countdown, reload at 2 ----
    game_active = 1'b1;
    cycles("start", 2);
    spd = 1'b1;
    cycle("speed_load");
    expect_val("speed_load_val", int'(speed_ms_left), SPEED_MS);
    begin
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        if (m_speed == 2) seen = 1;
        else cycle("speed_count");
      end
      if (!seen) bound_expired("speed_reach_2");
    end
    spd = 1'b0;
    cycle("speed_drop");
    spd = 1'b1;
    cycle("speed_reload");
    expect_val("speed_reload_val", int'(speed_ms_left), SPEED_MS);
    cycles("speed_expire", 4 * TICK_DIV * SPEED_MS);
    expect_val("speed_expired", int'(speed_active), 0);

    // ---- Asynchronous reset mid-run with speed active ----
    spd = 1'b0;
    cycle("rearm");
    spd = 1'b1;
    cycle("speed_again");
    expect_val("speed_again_on", int'(speed_active), 1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    cycles("post_reset", 10);
    expect_val("post_reset_speed", int'(speed_active), 0);

    // ---- Shield absorbs a hit, then grace window ----
    shd = 1'b1;
    cycle("shield_load");
    begin
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        if (m_shield == 4) seen = 1;
        else cycle("shield_count");
      end
      if (!seen) bound_expired("shield_reach_4");
    end
    col = 1'b1;
    cycle("absorb");
    expect_val("absorb_shield", int'(shield_active), 0);
    expect_val("absorb_invuln", int'(invuln_active), 1);
    expect_val("absorb_over", int'(game_over), 0);
    cycles("grace_run", TICK_DIV * GRACE_MS + 2);
    expect_val("grace_done", int'(invuln_active), 0);

    // ---- Unprotected hit ends the game; pickups then ignored ----
    col = 1'b0; spd = 1'b0; shd = 1'b0;
    cycle("clear_flags");
    col = 1'b1;
    cycle("fatal_hit");
    expect_val("fatal_over", int'(game_over), 1);
    spd = 1'b1; shd = 1'b1;
    cycles("over_pickups", 3);
    expect_val("over_speed", int'(speed_active), 0);
    expect_val("over_shield", int'(shield_active), 0);
    game_active = 1'b0;
    cycle("leave_over");
    expect_val("leave_over", int'(game_over), 0);

    // ---- Shield pickup and collision together: no protection ----
    col = 1'b0; spd = 1'b0; shd = 1'b0;
    cycle("idle");
    game_active = 1'b1;
    cycles("restart", 2);
    col = 1'b1; shd = 1'b1;
    cycle("same_cycle");
    expect_val("same_cycle_over", int'(game_over), 1);
    expect_val("same_cycle_shield", int'(shield_active), 0);

    // ---- Flags already high at game start do not fire ----
    game_active = 1'b0;
    cycle("to_idle");
    col = 1'b1; spd = 1'b1; shd = 1'b1;
    cycle("flags_high");
    game_active = 1'b1;
    cycles("start_high", 10);
    expect_val("start_high_over", int'(game_over), 0);

    // ---- Randomised play ----
    game_active = 1'b0;
    col = 1'b0; spd = 1'b0; shd = 1'b0;
    cycle("rand_prep");
    game_active = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) col = ~col;
      if ($urandom_range(0, 7) == 0) spd = ~spd;
      if ($urandom_range(0, 7) == 0) shd = ~shd;
      if ($urandom_range(0, 149) == 0) game_active = ~game_active;
      else if (!game_active && $urandom_range(0, 3) == 0) game_active = 1'b1;
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
